// File: rtl/glb_load_scheduler.sv
// DRAM-to-GLB load sequencer: arbitrates FILTER/BIAS/IFMAP load requests,
// issues one DRAM burst per request and streams the beats into consecutive GLB words.
`timescale 1ns/1ps
module glb_load_scheduler #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 64
) (
  input  logic                    core_clk,
  input  logic                    reset,
  input  logic [2:0]              req_valid,
  output logic [2:0]              req_ready,
  input  logic [3*ADDR_WIDTH-1:0] req_base_addr,
  input  logic [3*ADDR_WIDTH-1:0] req_num_words,
  output logic                    dram_rd_req,
  output logic [1:0]              dram_rd_type,
  output logic [ADDR_WIDTH-1:0]   dram_rd_len,
  input  logic [DATA_WIDTH-1:0]   dram_rdata,
  input  logic                    dram_rvalid,
  output logic                    dram_rready,
  output logic [2:0]              glb_we,
  output logic [ADDR_WIDTH-1:0]   glb_waddr,
  output logic [DATA_WIDTH-1:0]   glb_wdata,
  input  logic                    glb_wready,
  output logic [2:0]              done,
  output logic                    busy
);

  // state  | meaning
  // IDLE   | arbitrate pending requests, grant the winner
  // GRANT  | issue the DRAM burst (or skip it for a zero-length load)
  // STREAM | move DRAM beats into the GLB output register
  // DONE   | pulse done for the served type
  typedef enum logic [1:0] {IDLE, GRANT, STREAM, DONE} state_t;

  localparam logic [ADDR_WIDTH-1:0] ONE = ADDR_WIDTH'(1);

  state_t                state, state_nxt;
  logic [1:0]            win_type;
  logic [1:0]            type_q;
  logic [ADDR_WIDTH-1:0] len_q;
  logic [ADDR_WIDTH-1:0] remaining;
  logic [ADDR_WIDTH-1:0] addr_ptr;
  logic                  beat;
  logic                  wr_accept;

  function automatic logic [2:0] onehot(input logic [1:0] t);
    return 3'b001 << t;
  endfunction

  always_comb begin
    win_type = 2'd2;
    if (req_valid[0])      win_type = 2'd0;
    else if (req_valid[1]) win_type = 2'd1;
  end

  assign beat      = (state == STREAM) && dram_rvalid && dram_rready;
  assign wr_accept = (glb_we != 3'b000) && glb_wready;
  assign busy      = (state != IDLE);

  always_comb begin
    state_nxt    = state;
    req_ready    = 3'b000;
    dram_rd_req  = 1'b0;
    dram_rd_type = 2'd0;
    dram_rd_len  = '0;
    dram_rready  = 1'b0;
    done         = 3'b000;
    case (state)
      IDLE: begin
        // gated so a request held through reset never shows a grant
        if (req_valid != 3'b000 && !reset) begin
          req_ready = onehot(win_type);
          state_nxt = GRANT;
        end
      end
      GRANT: begin
        if (len_q != '0) begin
          dram_rd_req  = 1'b1;
          dram_rd_type = type_q;
          dram_rd_len  = len_q;
          state_nxt    = STREAM;
        end else begin
          state_nxt = DONE;
        end
      end
      STREAM: begin
        dram_rready = (remaining != '0) && ((glb_we == 3'b000) || glb_wready);
        // at most one write is ever outstanding, so this is the final one
        if (remaining == '0 && wr_accept) state_nxt = DONE;
      end
      DONE: begin
        done      = onehot(type_q);
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge core_clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      type_q    <= 2'd0;
      len_q     <= '0;
      remaining <= '0;
      addr_ptr  <= '0;
      glb_we    <= 3'b000;
      glb_waddr <= '0;
      glb_wdata <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && req_valid != 3'b000) begin
        type_q   <= win_type;
        len_q    <= req_num_words[int'(win_type)*ADDR_WIDTH +: ADDR_WIDTH];
        addr_ptr <= req_base_addr[int'(win_type)*ADDR_WIDTH +: ADDR_WIDTH];
      end
      if (state == GRANT) remaining <= len_q;
      if (beat) begin
        glb_we    <= onehot(type_q);
        glb_waddr <= addr_ptr;
        glb_wdata <= dram_rdata;
        addr_ptr  <= addr_ptr + ONE;
        remaining <= remaining - ONE;
      end else if (wr_accept) begin
        glb_we <= 3'b000;
      end
    end
  end

endmodule

// File: tb/tb_glb_load_scheduler.sv
// Directed bench for glb_load_scheduler: a DRAM beat source and event logger run
// beside one linear stimulus sequence that checks against hand-computed values.
`timescale 1ns/1ps
module tb_glb_load_scheduler;

  logic        core_clk;
  logic        reset;
  logic [2:0]  req_valid;
  logic [2:0]  req_ready;
  logic [47:0] req_base_addr;
  logic [47:0] req_num_words;
  logic        dram_rd_req;
  logic [1:0]  dram_rd_type;
  logic [15:0] dram_rd_len;
  logic [63:0] dram_rdata;
  logic        dram_rvalid;
  logic        dram_rready;
  logic [2:0]  glb_we;
  logic [15:0] glb_waddr;
  logic [63:0] glb_wdata;
  logic        glb_wready;
  logic [2:0]  done;
  logic        busy;

  glb_load_scheduler #(.ADDR_WIDTH(16), .DATA_WIDTH(64)) dut (
    .core_clk(core_clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_base_addr(req_base_addr), .req_num_words(req_num_words),
    .dram_rd_req(dram_rd_req), .dram_rd_type(dram_rd_type), .dram_rd_len(dram_rd_len),
    .dram_rdata(dram_rdata), .dram_rvalid(dram_rvalid), .dram_rready(dram_rready),
    .glb_we(glb_we), .glb_waddr(glb_waddr), .glb_wdata(glb_wdata), .glb_wready(glb_wready),
    .done(done), .busy(busy)
  );

  initial core_clk = 1'b0;
  always #5 core_clk = ~core_clk;

  typedef struct {logic [2:0] we; logic [15:0] addr; logic [63:0] data; int cyc;} wr_t;
  typedef struct {logic [2:0] v; int cyc;} ev_t;
  typedef struct {logic [1:0] t; logic [15:0] len; int cyc;} rd_t;

  wr_t wr_q[$];
  ev_t grant_q[$];
  ev_t done_q[$];
  rd_t rd_q[$];

  int         n_assert = 0;
  int         n_fail = 0;
  int         cyc = 0;
  int         pending = 0;
  int         beat_idx = 0;
  logic [1:0] cur_type = 2'd0;
  logic [2:0] req_hold;
  logic [2:0] granted = 3'b000;
  logic [2:0] clr_mask = 3'b000;
  logic       extra_rvalid;

  // requests stay up until granted, then drop until the stimulus releases them
  assign req_valid = req_hold & ~granted;

  function automatic logic [63:0] pat(input logic [1:0] t, input int i);
    return {14'h0, t, 32'hCAFE_0000, i[15:0]};
  endfunction

  function automatic logic [2:0] oh(input logic [1:0] t);
    return 3'b001 << t;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_done(input int target, input int budget);
    int k = 0;
    while (done_q.size() < target && k < budget) begin
      @(posedge core_clk); #2;
      k++;
    end
    check("done_timeout", 64'(done_q.size()), 64'(target));
  endtask

  task automatic wait_writes(input int target, input int budget);
    int k = 0;
    while (wr_q.size() < target && k < budget) begin
      @(posedge core_clk); #2;
      k++;
    end
    check("write_timeout", 64'(wr_q.size()), 64'(target));
  endtask

  task automatic check_writes(input string tag, input int start, input int n,
                              input logic [1:0] t, input logic [15:0] base);
    logic [15:0] a;
    for (int i = 0; i < n; i++) begin
      if (start + i < wr_q.size()) begin
        a = base + 16'(i);
        check({tag, "_we"},   64'(wr_q[start+i].we), 64'(oh(t)));
        check({tag, "_addr"}, 64'(wr_q[start+i].addr), 64'(a));
        check({tag, "_data"}, wr_q[start+i].data, pat(t, i));
      end
    end
  endtask

  // DRAM beat source and event logger; observes 1 ns before each rising edge
  always @(negedge core_clk) begin
    granted     = (granted | clr_mask) & req_hold;
    clr_mask    = 3'b000;
    dram_rvalid = (pending > 0) || extra_rvalid;
    dram_rdata  = pat(cur_type, beat_idx);
    #4;
    cyc++;
    if (reset) begin
      pending  = 0;
      beat_idx = 0;
    end else begin
      if (req_ready != 3'b000) begin
        grant_q.push_back('{v: req_ready, cyc: cyc});
        clr_mask = req_ready;
      end
      if (dram_rd_req) begin
        rd_q.push_back('{t: dram_rd_type, len: dram_rd_len, cyc: cyc});
        pending  = int'(dram_rd_len);
        beat_idx = 0;
        cur_type = dram_rd_type;
      end
      if (dram_rvalid && dram_rready) begin
        beat_idx++;
        if (pending > 0) pending--;
      end
      if (glb_we != 3'b000 && glb_wready)
        wr_q.push_back('{we: glb_we, addr: glb_waddr, data: glb_wdata, cyc: cyc});
      if (done != 3'b000) done_q.push_back('{v: done, cyc: cyc});
    end
  end

  initial begin
    int w0, d0, g0, r0;
    reset         = 1'b1;
    req_hold      = 3'b000;
    req_base_addr = '0;
    req_num_words = '0;
    glb_wready    = 1'b1;
    extra_rvalid  = 1'b0;

    // reset state, with requests pending
    repeat (2) @(negedge core_clk);
    req_hold = 3'b111; #1;
    check("rst_req_ready", 64'(req_ready), 64'(0));
    check("rst_rd_req", 64'(dram_rd_req), 64'(0));
    check("rst_rready", 64'(dram_rready), 64'(0));
    check("rst_glb_we", 64'(glb_we), 64'(0));
    check("rst_waddr", 64'(glb_waddr), 64'(0));
    check("rst_wdata", glb_wdata, 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    @(negedge core_clk); req_hold = 3'b000;
    @(negedge core_clk); reset = 1'b0;
    repeat (2) @(negedge core_clk);

    // FILTER only, base 0x0010, len 4
    w0 = wr_q.size(); d0 = done_q.size(); g0 = grant_q.size(); r0 = rd_q.size();
    req_base_addr[15:0] = 16'h0010;
    req_num_words[15:0] = 16'd4;
    req_hold = 3'b001; #1;
    check("t1_req_ready", 64'(req_ready), 64'(3'b001));
    check("t1_busy_idle", 64'(busy), 64'(0));
    @(negedge core_clk); #1;
    check("t1_rd_req", 64'(dram_rd_req), 64'(1));
    check("t1_rd_type", 64'(dram_rd_type), 64'(0));
    check("t1_rd_len", 64'(dram_rd_len), 64'(4));
    check("t1_busy", 64'(busy), 64'(1));
    wait_done(d0 + 1, 50);
    check("t1_busy_after", 64'(busy), 64'(0));
    check("t1_nwr", 64'(wr_q.size() - w0), 64'(4));
    check_writes("t1", w0, 4, 2'd0, 16'h0010);
    if (wr_q.size() >= w0 + 4 && done_q.size() > d0) begin
      check("t1_consec", 64'(wr_q[w0+3].cyc - wr_q[w0].cyc), 64'(3));
      check("t1_done_lat", 64'(done_q[d0].cyc - wr_q[w0+3].cyc), 64'(1));
      check("t1_done_val", 64'(done_q[d0].v), 64'(3'b001));
    end
    if (rd_q.size() > r0 && grant_q.size() > g0)
      check("t1_rd_lat", 64'(rd_q[r0].cyc - grant_q[g0].cyc), 64'(1));
    check("t1_ndone", 64'(done_q.size() - d0), 64'(1));
    req_hold = 3'b000;
    repeat (2) @(negedge core_clk);

    // all three at once: served FILTER, BIAS, IFMAP
    w0 = wr_q.size(); d0 = done_q.size(); g0 = grant_q.size(); r0 = rd_q.size();
    req_base_addr = {16'h0300, 16'h0200, 16'h0100};
    req_num_words = {16'd8, 16'd24, 16'd2};
    req_hold = 3'b111; #1;
    check("t2_first_grant", 64'(req_ready), 64'(3'b001));
    wait_done(d0 + 3, 300);
    check("t2_nwr", 64'(wr_q.size() - w0), 64'(34));
    check_writes("t2f", w0, 2, 2'd0, 16'h0100);
    check_writes("t2b", w0 + 2, 24, 2'd1, 16'h0200);
    check_writes("t2i", w0 + 26, 8, 2'd2, 16'h0300);
    for (int i = 0; i < 3; i++) begin
      if (grant_q.size() > g0 + i) check("t2_grant_ord", 64'(grant_q[g0+i].v), 64'(oh(2'(i))));
      if (done_q.size() > d0 + i)  check("t2_done_ord", 64'(done_q[d0+i].v), 64'(oh(2'(i))));
      if (rd_q.size() > r0 + i)    check("t2_rd_type", 64'(rd_q[r0+i].t), 64'(i));
    end
    if (rd_q.size() > r0 + 2) begin
      check("t2_rd_len0", 64'(rd_q[r0].len), 64'(2));
      check("t2_rd_len1", 64'(rd_q[r0+1].len), 64'(24));
      check("t2_rd_len2", 64'(rd_q[r0+2].len), 64'(8));
    end
    req_hold = 3'b000;
    repeat (2) @(negedge core_clk);

    // BIAS len 24 with a 3-cycle GLB stall after the 5th write
    w0 = wr_q.size(); d0 = done_q.size();
    req_base_addr[31:16] = 16'h0400;
    req_num_words[31:16] = 16'd24;
    req_hold = 3'b010;
    wait_writes(w0 + 5, 60);
    @(negedge core_clk);
    glb_wready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("t3_stall_we", 64'(glb_we), 64'(3'b010));
      check("t3_stall_addr", 64'(glb_waddr), 64'(16'h0405));
      check("t3_stall_data", glb_wdata, pat(2'd1, 5));
      check("t3_stall_rready", 64'(dram_rready), 64'(0));
      @(negedge core_clk);
    end
    glb_wready = 1'b1;
    wait_done(d0 + 1, 80);
    check("t3_nwr", 64'(wr_q.size() - w0), 64'(24));
    check_writes("t3", w0, 24, 2'd1, 16'h0400);
    if (done_q.size() > d0) check("t3_done_val", 64'(done_q[d0].v), 64'(3'b010));
    req_hold = 3'b000;
    repeat (2) @(negedge core_clk);

    // IFMAP base 0xFFFE, len 4: addresses wrap; surplus DRAM beats ignored
    w0 = wr_q.size(); d0 = done_q.size();
    req_base_addr[47:32] = 16'hFFFE;
    req_num_words[47:32] = 16'd4;
    extra_rvalid = 1'b1;
    req_hold = 3'b100;
    wait_done(d0 + 1, 50);
    repeat (3) @(negedge core_clk);
    check("t4_nwr", 64'(wr_q.size() - w0), 64'(4));
    check_writes("t4", w0, 4, 2'd2, 16'hFFFE);
    if (done_q.size() > d0) check("t4_done_val", 64'(done_q[d0].v), 64'(3'b100));
    extra_rvalid = 1'b0;
    req_hold = 3'b000;
    repeat (2) @(negedge core_clk);

    // FILTER len 0: grant, no burst, no write, done two cycles after grant
    w0 = wr_q.size(); d0 = done_q.size(); g0 = grant_q.size(); r0 = rd_q.size();
    req_num_words[15:0] = 16'd0;
    req_hold = 3'b001; #1;
    check("t5_req_ready", 64'(req_ready), 64'(3'b001));
    wait_done(d0 + 1, 20);
    check("t5_no_rd", 64'(rd_q.size() - r0), 64'(0));
    check("t5_no_wr", 64'(wr_q.size() - w0), 64'(0));
    if (done_q.size() > d0 && grant_q.size() > g0) begin
      check("t5_done_val", 64'(done_q[d0].v), 64'(3'b001));
      check("t5_done_lat", 64'(done_q[d0].cyc - grant_q[g0].cyc), 64'(2));
    end
    req_hold = 3'b000;
    repeat (2) @(negedge core_clk);

    // reset after the 3rd of 8 IFMAP writes, then a fresh FILTER load
    w0 = wr_q.size(); d0 = done_q.size();
    req_base_addr[47:32] = 16'h0500;
    req_num_words[47:32] = 16'd8;
    req_hold = 3'b100;
    wait_writes(w0 + 3, 40);
    reset = 1'b1; #1;
    check("t6_rst_req_ready", 64'(req_ready), 64'(0));
    check("t6_rst_rd_req", 64'(dram_rd_req), 64'(0));
    check("t6_rst_rd_type", 64'(dram_rd_type), 64'(0));
    check("t6_rst_rd_len", 64'(dram_rd_len), 64'(0));
    check("t6_rst_rready", 64'(dram_rready), 64'(0));
    check("t6_rst_we", 64'(glb_we), 64'(0));
    check("t6_rst_waddr", 64'(glb_waddr), 64'(0));
    check("t6_rst_wdata", glb_wdata, 64'(0));
    check("t6_rst_done", 64'(done), 64'(0));
    check("t6_rst_busy", 64'(busy), 64'(0));
    req_hold = 3'b000;
    repeat (2) @(negedge core_clk);
    reset = 1'b0;
    repeat (4) @(negedge core_clk);
    check("t6_no_done", 64'(done_q.size() - d0), 64'(0));
    check("t6_idle_busy", 64'(busy), 64'(0));
    w0 = wr_q.size(); d0 = done_q.size();
    req_base_addr[15:0] = 16'h0600;
    req_num_words[15:0] = 16'd3;
    req_hold = 3'b001; #1;
    check("t6_req_ready", 64'(req_ready), 64'(3'b001));
    wait_done(d0 + 1, 40);
    check("t6_nwr", 64'(wr_q.size() - w0), 64'(3));
    check_writes("t6", w0, 3, 2'd0, 16'h0600);
    if (done_q.size() > d0) check("t6_done_val", 64'(done_q[d0].v), 64'(3'b001));
    req_hold = 3'b000;
    repeat (2) @(negedge core_clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
